dmem_write_buffer: RTL and testbench
====================================

Name: dmem_write_buffer

Overview:
- Posted-store buffer downstream of the single-cycle core's data-memory port.
- Accepts the core's store triplet (MemWrite, ALUResult address, WriteData) in one cycle, queues it, and drains it to a slower backing data memory over a valid/ready handshake.
- Returns ReadData to the core with store-to-load forwarding from queued entries, so the core sees program-order memory semantics.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- ADDR_W, 32, byte-address width
- DATA_W, 32, data word width

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- MemWrite  input  1  core store strobe for the current cycle
- Addr  input  ADDR_W  core byte address (ALUResult); word-aligned, bits [1:0] ignored
- WriteData  input  DATA_W  core store data
- ReadData  output  DATA_W  load data to core, combinational from Addr
- Full  output  1  buffer holds DEPTH entries
- Empty  output  1  no entries pending; used as store fence
- Overflow  output  1  sticky: a store was dropped
- MemReqValid  output  1  head entry offered to backing memory
- MemReqReady  input  1  backing memory accepts the head entry
- MemReqAddr  output  ADDR_W  head entry address
- MemReqData  output  DATA_W  head entry data
- MemRdAddr  output  ADDR_W  equals Addr, for backing-memory async read
- MemRdData  input  DATA_W  backing-memory read data

Behaviour:
- Storage: circular FIFO. Head/tail pointers are log2(DEPTH) bits with natural wrap. Count is log2(DEPTH)+1 bits.
- Reset (async assert, sync release) sets head=tail=count=0, Overflow=0, MemReqValid=0, Empty=1, Full=0. Entry contents are don't-care. Reset mid-drain discards all pending stores.
- Pop: fires when MemReqValid && MemReqReady. MemReqValid = !Empty. MemReqAddr and MemReqData come from the head entry. They must stay stable while Valid && !Ready. Valid never drops without a pop.
- Push: MemWrite with count<DEPTH writes the tail entry; tail advances on the next CLK edge. Latency from store to first MemReqValid is 1 cycle when the buffer was empty.
- Simultaneous push and pop while Full: accepted. Count unchanged, both pointers advance.
- Push while Full with no pop: the store is dropped and Overflow sets on that edge. Overflow clears only on reset.
- Simultaneous push and pop while count==1: the old head drains, the new entry becomes the head, and Empty stays 0.
- Full = (count==DEPTH). Empty = (count==0). Both are registered-state derived, with no combinational path from MemWrite.
- Forwarding:
  - ReadData = data of the youngest valid entry whose Addr[ADDR_W-1:2] matches; otherwise MemRdData.
  - The entry being popped this cycle still forwards, since memory commit timing is unknown.
  - The current-cycle MemWrite is not forwarded; the core never loads and stores in the same cycle.
- Arithmetic: only the word address is compared. No byte enables; every store is a full word.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a store whose word address matches the youngest entry (tail-1) overwrites that entry's data instead of pushing. This applies even when Full, so no Overflow results.
- Exception: no coalescing when that entry is the head and is popping this cycle; a normal push follows instead.
- Undefined: every store pushes; identical addresses occupy separate entries.

Decomposition:
- Package dmem_wb_pkg holds:
  - default DEPTH/ADDR_W/DATA_W constants
  - wb_entry_t typedef (word address, data)
  - the pointer-width function clog2-based constant
- One sub-module, wb_fwd_match: a combinational youngest-first priority matcher over the DEPTH entries, given the head pointer and count. It outputs hit and data.
- The FIFO control stays in the top module.

Test Plan:
- Reset with MemReqReady=0, then stores to 0x10=0xAAAA0001 and 0x14=0xAAAA0002 -> count 2. MemReqValid rises the cycle after the first store. MemReqAddr/Data hold 0x10/0xAAAA0001 until Ready. Then pops arrive in order and Empty=1.
- Ready=0, then fill 4 stores, then a 5th store to 0x40 -> Full=1, 5th dropped, Overflow=1 and remains 1. Draining delivers exactly the 4 original entries.
- Full, with Ready=1 and a store to 0x50 in the same cycle -> accepted, count stays 4. Drain order ends with 0x50.
- Stores 0x20=0x1 then 0x20=0x2 queued, MemRdData=0xDEAD, Addr=0x22 -> ReadData=0x2 (youngest, low bits ignored). Addr=0x24 -> ReadData=0xDEAD.
- Two queued stores, then Reset pulsed low mid-handshake asynchronously -> MemReqValid=0, Empty=1, Overflow=0 immediately, without waiting for a CLK edge.
- With WB_COALESCE_EN: Ready=0, stores 0x30=0x5 then 0x30=0x6 -> count 1 and the drain delivers 0x30/0x6. Without the macro -> count 2 and both values are delivered in order.

Source files
------------

// File: rtl/dmem_wb_pkg.sv
// rtl/dmem_wb_pkg.sv - shared constants, entry type and pointer sizing for the write buffer
package dmem_wb_pkg;

   localparam int WB_DEPTH  = 4;
   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 32;

   function automatic int wb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   localparam int WB_PTR_W = wb_ptr_w(WB_DEPTH);

   // Word address only: the two byte-offset bits are never stored.
   typedef struct packed {
      logic [WB_ADDR_W-3:0] waddr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-first store-to-load forwarding matcher over the queued entries
module wb_fwd_match
   import dmem_wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = WB_ADDR_W - 2,
   parameter int DW    = WB_DATA_W
) (
   input  logic [AW-1:0]            waddr [DEPTH],
   input  logic [DW-1:0]            data  [DEPTH],
   input  logic [wb_ptr_w(DEPTH)-1:0] head,
   input  logic [wb_ptr_w(DEPTH):0]   count,
   input  logic [AW-1:0]            rd_waddr,
   output logic                     hit,
   output logic [DW-1:0]            hit_data
);

   localparam int PW = wb_ptr_w(DEPTH);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (((PW+1)'(i) < count) && (waddr[idx] == rd_waddr)) begin
            hit      = 1'b1;
            hit_data = data[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - posted-store FIFO with forwarding; WB_COALESCE_EN merges same-word stores
module dmem_write_buffer
   import dmem_wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              Full,
   output logic              Empty,
   output logic              Overflow,
   output logic              MemReqValid,
   input  logic              MemReqReady,
   output logic [ADDR_W-1:0] MemReqAddr,
   output logic [DATA_W-1:0] MemReqData,
   output logic [ADDR_W-1:0] MemRdAddr,
   input  logic [DATA_W-1:0] MemRdData
);

   localparam int PW = wb_ptr_w(DEPTH);
   localparam int AW = ADDR_W - 2;

   logic [AW-1:0]     waddr_q [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [PW-1:0]     yng;
   logic [PW:0]       count;
   logic              overflow_q;
   logic              full;
   logic              empty;
   logic              pop;
   logic              push;
   logic              coal;
   logic              drop;
   logic [AW-1:0]     in_waddr;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   assign in_waddr = Addr[ADDR_W-1:2];
   assign empty    = (count == '0);
   assign full     = (count == (PW+1)'(DEPTH));
   assign yng      = tail - PW'(1);
   assign pop      = !empty && MemReqReady;

`ifdef WB_COALESCE_EN
   // A lone head that is draining this cycle cannot absorb the store.
   assign coal = MemWrite && !empty && (waddr_q[yng] == in_waddr)
                 && !((count == (PW+1)'(1)) && pop);
`else
   assign coal = 1'b0;
`endif

   assign push = MemWrite && !coal && (!full || pop);
   assign drop = MemWrite && !coal && full && !pop;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (drop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         waddr_q[tail] <= in_waddr;
         data_q[tail]  <= WriteData;
      end
      if (coal) data_q[yng] <= WriteData;
   end

   wb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DATA_W)
   ) u_fwd (
      .waddr    (waddr_q),
      .data     (data_q),
      .head     (head),
      .count    (count),
      .rd_waddr (in_waddr),
      .hit      (fwd_hit),
      .hit_data (fwd_data)
   );

   assign ReadData    = fwd_hit ? fwd_data : MemRdData;
   assign Full        = full;
   assign Empty       = empty;
   assign Overflow    = overflow_q;
   assign MemReqValid = !empty;
   assign MemReqAddr  = {waddr_q[head], 2'b00};
   assign MemReqData  = data_q[head];
   assign MemRdAddr   = Addr;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - queue-model bench for dmem_write_buffer, directed plan plus random traffic
module tb_dmem_write_buffer;

   localparam int DEPTH = 4;

   logic        CLK;
   logic        Reset;
   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Full;
   logic        Empty;
   logic        Overflow;
   logic        MemReqValid;
   logic        MemReqReady;
   logic [31:0] MemReqAddr;
   logic [31:0] MemReqData;
   logic [31:0] MemRdAddr;
   logic [31:0] MemRdData;

   dmem_write_buffer dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .MemWrite    (MemWrite),
      .Addr        (Addr),
      .WriteData   (WriteData),
      .ReadData    (ReadData),
      .Full        (Full),
      .Empty       (Empty),
      .Overflow    (Overflow),
      .MemReqValid (MemReqValid),
      .MemReqReady (MemReqReady),
      .MemReqAddr  (MemReqAddr),
      .MemReqData  (MemReqData),
      .MemRdAddr   (MemRdAddr),
      .MemRdData   (MemRdData)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   ent_t  mq[$];
   ent_t  dlog[$];
   bit    movf;
   bit    cmp_en;
   int    checks;
   int    errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain queue in program order, updated at every clock edge.
   always @(posedge CLK) begin
      int n;
      bit p;
      bit c;
      if (!Reset) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         n = mq.size();
         p = (n > 0) && MemReqReady;
         c = 1'b0;
`ifdef WB_COALESCE_EN
         c = MemWrite && (n > 0) && (mq[n-1].addr == {Addr[31:2], 2'b00}) && !(n == 1 && p);
`endif
         if (p) void'(mq.pop_front());
         if (c) mq[mq.size()-1].data = WriteData;
         else if (MemWrite) begin
            if (n < DEPTH || p) mq.push_back('{addr: {Addr[31:2], 2'b00}, data: WriteData});
            else movf = 1'b1;
         end
      end
   end

   always @(negedge CLK) begin
      int n;
      logic [31:0] exp_rd;
      if (cmp_en) begin
         n = mq.size();
         exp_rd = MemRdData;
         for (int i = 0; i < n; i++)
            if (mq[i].addr[31:2] == Addr[31:2]) exp_rd = mq[i].data;
         chk("empty", 32'(Empty), 32'(n == 0));
         chk("full", 32'(Full), 32'(n == DEPTH));
         chk("valid", 32'(MemReqValid), 32'(n != 0));
         chk("overflow", 32'(Overflow), 32'(movf));
         chk("readdata", ReadData, exp_rd);
         chk("rdaddr", MemRdAddr, Addr);
         if (n > 0) begin
            chk("reqaddr", MemReqAddr, mq[0].addr);
            chk("reqdata", MemReqData, mq[0].data);
         end
         if (MemReqValid && MemReqReady) dlog.push_back('{addr: MemReqAddr, data: MemReqData});
      end
   end

   task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      MemWrite    = mw;
      Addr        = a;
      WriteData   = d;
      MemReqReady = rdy;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
      if (idx < dlog.size()) begin
         chk({name, "_addr"}, dlog[idx].addr, a);
         chk({name, "_data"}, dlog[idx].data, d);
      end else begin
         chk({name, "_present"}, 32'(dlog.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cmp_en = 1'b0;
      Reset = 1'b0;
      MemWrite = 1'b0;
      Addr = '0;
      WriteData = '0;
      MemReqReady = 1'b0;
      MemRdData = 32'hDEAD;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_empty", 32'(Empty), 32'd1);
      chk("rst_full", 32'(Full), 32'd0);
      chk("rst_valid", 32'(MemReqValid), 32'd0);
      chk("rst_ovf", 32'(Overflow), 32'd0);
      Reset = 1'b1;
      cmp_en = 1'b1;

      // Two posted stores held by a stalled memory, then drained in order.
      step(1, 32'h10, 32'hAAAA0001, 0);
      chk("t1_valid_rise", 32'(MemReqValid), 32'd1);
      chk("t1_head_addr", MemReqAddr, 32'h10);
      step(1, 32'h14, 32'hAAAA0002, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t1_hold_addr", MemReqAddr, 32'h10);
      chk("t1_hold_data", MemReqData, 32'hAAAA0001);
      dlog.delete();
      repeat (3) step(0, 0, 0, 1);
      chk("t1_empty", 32'(Empty), 32'd1);
      chk("t1_npop", 32'(dlog.size()), 32'd2);
      chk_log("t1_pop0", 0, 32'h10, 32'hAAAA0001);
      chk_log("t1_pop1", 1, 32'h14, 32'hAAAA0002);

      // Fill, then a dropped fifth store.
      for (int k = 0; k < 4; k++) step(1, 32'h100 + 32'(4 * k), 32'hB0 + 32'(k), 0);
      chk("t2_full", 32'(Full), 32'd1);
      step(1, 32'h40, 32'h4444, 0);
      chk("t2_ovf", 32'(Overflow), 32'd1);
      step(0, 0, 0, 0);
      dlog.delete();
      repeat (5) step(0, 0, 0, 1);
      chk("t2_npop", 32'(dlog.size()), 32'd4);
      for (int k = 0; k < 4; k++) chk_log("t2_pop", k, 32'h100 + 32'(4 * k), 32'hB0 + 32'(k));
      chk("t2_ovf_sticky", 32'(Overflow), 32'd1);

      // Push and pop together while full.
      dlog.delete();
      for (int k = 0; k < 4; k++) step(1, 32'h200 + 32'(4 * k), 32'hC0 + 32'(k), 0);
      step(1, 32'h50, 32'h5555, 1);
      chk("t3_full_kept", 32'(Full), 32'd1);
      repeat (5) step(0, 0, 0, 1);
      chk("t3_npop", 32'(dlog.size()), 32'd5);
      chk_log("t3_last", 4, 32'h50, 32'h5555);

      // Forwarding: youngest match wins, byte offset ignored, popping entry still forwards.
      step(1, 32'h20, 32'h1, 0);
      step(1, 32'h20, 32'h2, 0);
      MemWrite = 1'b0;
      Addr = 32'h22;
      MemRdData = 32'hDEAD;
      #1 chk("t4_fwd_young", ReadData, 32'h2);
      Addr = 32'h24;
      #1 chk("t4_fwd_miss", ReadData, 32'hDEAD);
      Addr = 32'h20;
      MemReqReady = 1'b1;
      #1 chk("t4_fwd_popping", ReadData, 32'h2);
      MemReqReady = 1'b0;
      @(posedge CLK);
      #1;

      // Asynchronous reset mid-handshake with entries pending and Overflow set.
      MemReqReady = 1'b1;
      #2;
      Reset = 1'b0;
      mq.delete();
      movf = 1'b0;
      #1;
      chk("t5_valid", 32'(MemReqValid), 32'd0);
      chk("t5_empty", 32'(Empty), 32'd1);
      chk("t5_ovf", 32'(Overflow), 32'd0);
      @(posedge CLK);
      #1;
      Reset = 1'b1;
      MemReqReady = 1'b0;

      // Same-word stores: merged or kept separate depending on the build.
      step(1, 32'h30, 32'h5, 0);
      step(1, 32'h30, 32'h6, 0);
      dlog.delete();
      repeat (3) step(0, 0, 0, 1);
`ifdef WB_COALESCE_EN
      chk("t6_npop", 32'(dlog.size()), 32'd1);
      chk_log("t6_pop0", 0, 32'h30, 32'h6);
`else
      chk("t6_npop", 32'(dlog.size()), 32'd2);
      chk_log("t6_pop0", 0, 32'h30, 32'h5);
      chk_log("t6_pop1", 1, 32'h30, 32'h6);
`endif

      // Random traffic over a small address window; slow memory first, then faster.
      for (int c = 0; c < 800; c++) begin
         MemRdData = $urandom;
         step($urandom_range(0, 1) == 1,
              32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)),
              $urandom,
              (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) < 3));
      end
      repeat (6) step(0, 0, 0, 1);
      chk("final_empty", 32'(Empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
